// File: rtl/nandy_seq_defs.sv
// Shared definitions for the cycle sequencer: state encodings and
// fixed instruction values.
package nandy_seq_defs;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC0 = 2'd1,
        ST_EXEC1 = 2'd2,
        ST_INTR  = 2'd3
    } seq_state_t;

    localparam logic [7:0] INT_VEC_DEFAULT = 8'hF0;
    localparam logic [7:0] INST_RESET      = 8'h00;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for a single asynchronous level input.
// STAGES flops deep (1..3); all stages clear on rst.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cycle_sequencer.sv
// Instruction fetch/execute sequencer feeding the combinational control
// decoder. Handles memory wait states, the interrupt-enable flag and
// injection of the interrupt instruction between instructions.
// Optional single-step mode: define SEQ_SINGLE_STEP_EN to add the
// step input and halted output.
module cycle_sequencer
    import nandy_seq_defs::*;
#(
    parameter logic [7:0] INT_VEC     = INT_VEC_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inst_in,
    input  logic       mem_ready,
    input  logic       two_cycle,
    input  logic       mem_access,
    input  logic       cli,
    input  logic       sti,
    input  logic       irq,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step,
    output logic       halted,
`endif
    output logic [7:0] inst,
    output logic       cycle,
    output logic       fetch_req,
    output logic       exec_en,
    output logic       pc_inc,
    output logic       int_ack,
    output logic       int_en
);

    seq_state_t state_q;
    logic [7:0] inst_q;
    logic       int_en_q;
    logic       irq_sync;
    logic       mem_stall;
    logic       in_exec;
    logic       eoi;
    logic       take_int;
    logic       fetch_ok;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_irq_sync (
        .clk (clk),
        .rst (rst),
        .d_i (irq),
        .q_o (irq_sync)
    );

    assign mem_stall = mem_access && !mem_ready;
    assign in_exec   = (state_q == ST_EXEC0) || (state_q == ST_EXEC1);
    assign exec_en   = in_exec && !mem_stall;
    assign eoi       = exec_en && ((state_q == ST_EXEC1) || !two_cycle);
    // Interrupt decision uses the flag as it stood before this clock's cli/sti.
    assign take_int  = irq_sync && int_en_q;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_q;
    logic armed_q;
    logic armed_d;
    logic step_rise;

    assign step_rise = step && !step_q;
    // A step edge arriving on the EOI clock still arms the next fetch.
    assign armed_d   = step_rise ? 1'b1 : (eoi ? 1'b0 : armed_q);
    assign fetch_ok  = armed_q;
    assign halted    = (state_q == ST_FETCH) && !armed_q && !rst;

    // Track step edges and hold the fetch permission until the next EOI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            step_q  <= step;
            armed_q <= armed_d;
        end
    end
`else
    assign fetch_ok = 1'b1;
`endif

    // Main sequencing FSM: state, instruction register and interrupt enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            inst_q   <= INST_RESET;
            int_en_q <= 1'b0;
        end else begin
            if (exec_en) begin
                if (cli) begin
                    int_en_q <= 1'b0;
                end else if (sti) begin
                    int_en_q <= 1'b1;
                end
            end
            case (state_q)
                ST_FETCH: begin
                    if (fetch_ok && mem_ready) begin
                        inst_q  <= inst_in;
                        state_q <= ST_EXEC0;
                    end
                end
                ST_EXEC0: begin
                    if (exec_en) begin
                        if (two_cycle) begin
                            state_q <= ST_EXEC1;
                        end else begin
                            state_q <= take_int ? ST_INTR : ST_FETCH;
                        end
                    end
                end
                ST_EXEC1: begin
                    if (exec_en) begin
                        state_q <= take_int ? ST_INTR : ST_FETCH;
                    end
                end
                ST_INTR: begin
                    inst_q   <= INT_VEC;
                    int_en_q <= 1'b0;
                    state_q  <= ST_EXEC0;
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    assign inst      = inst_q;
    assign int_en    = int_en_q;
    assign cycle     = (state_q == ST_EXEC1);
    assign int_ack   = (state_q == ST_INTR);
    assign fetch_req = (state_q == ST_FETCH) && fetch_ok && !rst;
    assign pc_inc    = eoi;

endmodule
